// File: rtl/thresholding_param_loader_if.sv
// Bundles the threshold stream input and the AXI-Lite write channels
// of the parameter loader. The master side belongs to the loader.
interface thresholding_param_loader_if #(
  parameter int ADDR_BITS  = 8,
  parameter int TDATA_BITS = 16
);
  logic                  s_axis_tready;
  logic                  s_axis_tvalid;
  logic [TDATA_BITS-1:0] s_axis_tdata;

  logic                  m_axilite_AWVALID;
  logic                  m_axilite_AWREADY;
  logic [ADDR_BITS-1:0]  m_axilite_AWADDR;
  logic                  m_axilite_WVALID;
  logic                  m_axilite_WREADY;
  logic [31:0]           m_axilite_WDATA;
  logic [3:0]            m_axilite_WSTRB;
  logic                  m_axilite_BVALID;
  logic                  m_axilite_BREADY;
  logic [1:0]            m_axilite_BRESP;

  modport master (
    output s_axis_tready,
    input  s_axis_tvalid, s_axis_tdata,
    output m_axilite_AWVALID, m_axilite_AWADDR,
    input  m_axilite_AWREADY,
    output m_axilite_WVALID, m_axilite_WDATA, m_axilite_WSTRB,
    input  m_axilite_WREADY,
    input  m_axilite_BVALID, m_axilite_BRESP,
    output m_axilite_BREADY
  );

  modport slave (
    input  s_axis_tready,
    output s_axis_tvalid, s_axis_tdata,
    input  m_axilite_AWVALID, m_axilite_AWADDR,
    output m_axilite_AWREADY,
    input  m_axilite_WVALID, m_axilite_WDATA, m_axilite_WSTRB,
    output m_axilite_WREADY,
    output m_axilite_BVALID, m_axilite_BRESP,
    input  m_axilite_BREADY
  );
endinterface

// File: rtl/thresholding_param_loader.sv
// Streams a full threshold set into the thresholding adapter, one
// AXI-Lite write per stream word, addressed as {cf, pe, t, 2'b00}.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// FETCH | tready high, waiting for the next threshold word
// ISSUE | AW and W presented; each drops on its own handshake
// RESP  | BREADY high, waiting for the write response
module thresholding_param_loader #(
  parameter int N      = 4,
  parameter int K      = 16,
  parameter int C      = 1,
  parameter int PE     = 1,
  parameter int SIGNED = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  thresholding_param_loader_if.master bus
);
  localparam int CF        = 1 + (C - 1) / PE;
  localparam int PE_BITS   = $clog2(PE);
  localparam int CF_BITS   = $clog2(CF);
  localparam int ADDR_BITS = CF_BITS + PE_BITS + N + 2;
  // Zero-width fields still need a 1-bit counter; it simply stays 0.
  localparam int PE_W      = (PE_BITS > 0) ? PE_BITS : 1;
  localparam int CF_W      = (CF_BITS > 0) ? CF_BITS : 1;
  localparam logic [N-1:0]    T_LAST  = N'((2 ** N) - 2);
  localparam logic [PE_W-1:0] PE_LAST = PE_W'(PE - 1);
  localparam logic [CF_W-1:0] CF_LAST = CF_W'(CF - 1);

  if (C % PE != 0) begin : g_bad_fold
    $error("thresholding_param_loader: C must be a multiple of PE");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_RESP} state_t;

  state_t                 state, state_nx;
  logic [N-1:0]           t_cnt;
  logic [PE_W-1:0]        pe_cnt;
  logic [CF_W-1:0]        cf_cnt;
  logic [ADDR_BITS-1:0]   addr_q, addr_nx;
  logic [31:0]            data_q;
  logic                   aw_ok, w_ok;
  logic                   aw_hs, w_hs, last_word, start_ok;

  function automatic logic [31:0] extend(input logic [K-1:0] v);
    if (SIGNED != 0) return 32'($signed(v));
    return 32'(v);
  endfunction

  assign aw_hs     = bus.m_axilite_AWVALID && bus.m_axilite_AWREADY;
  assign w_hs      = bus.m_axilite_WVALID && bus.m_axilite_WREADY;
  assign last_word = (t_cnt == T_LAST) && (pe_cnt == PE_LAST) && (cf_cnt == CF_LAST);
  // A start coinciding with the done pulse is deliberately dropped.
  assign start_ok  = start && !done;
  assign addr_nx   = (ADDR_BITS'(cf_cnt) << (N + 2 + PE_BITS))
                   | (ADDR_BITS'(pe_cnt) << (N + 2))
                   | (ADDR_BITS'(t_cnt) << 2);

  assign bus.m_axilite_AWADDR = addr_q;
  assign bus.m_axilite_WDATA  = data_q;
  assign bus.m_axilite_WSTRB  = 4'hF;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nx              = state;
    busy                  = (state != S_IDLE);
    bus.s_axis_tready     = 1'b0;
    bus.m_axilite_AWVALID = 1'b0;
    bus.m_axilite_WVALID  = 1'b0;
    bus.m_axilite_BREADY  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nx = S_FETCH;
      end
      S_FETCH: begin
        bus.s_axis_tready = 1'b1;
        if (bus.s_axis_tvalid) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        bus.m_axilite_AWVALID = !aw_ok;
        bus.m_axilite_WVALID  = !w_ok;
        if ((aw_ok || aw_hs) && (w_ok || w_hs)) state_nx = S_RESP;
      end
      S_RESP: begin
        bus.m_axilite_BREADY = 1'b1;
        if (bus.m_axilite_BVALID) state_nx = last_word ? S_IDLE : S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Counters, captured word, channel-done flags and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_cnt  <= '0;
      pe_cnt <= '0;
      cf_cnt <= '0;
      addr_q <= '0;
      data_q <= '0;
      aw_ok  <= 1'b0;
      w_ok   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            t_cnt  <= '0;
            pe_cnt <= '0;
            cf_cnt <= '0;
            err    <= 1'b0;
          end
        end
        S_FETCH: begin
          if (bus.s_axis_tvalid) begin
            addr_q <= addr_nx;
            data_q <= extend(bus.s_axis_tdata[K-1:0]);
            aw_ok  <= 1'b0;
            w_ok   <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (aw_hs) aw_ok <= 1'b1;
          if (w_hs)  w_ok  <= 1'b1;
        end
        S_RESP: begin
          if (bus.m_axilite_BVALID) begin
            if (bus.m_axilite_BRESP != 2'b00) err <= 1'b1;
            if (last_word) begin
              done <= 1'b1;
            end else if (t_cnt != T_LAST) begin
              t_cnt <= t_cnt + 1'b1;
            end else begin
              t_cnt <= '0;
              if (pe_cnt != PE_LAST) begin
                pe_cnt <= pe_cnt + 1'b1;
              end else begin
                pe_cnt <= '0;
                cf_cnt <= cf_cnt + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_thresholding_param_loader.sv
// Bench for thresholding_param_loader: a randomizing AXI-Lite slave and
// stream source, checked against an address/data model of the load.
module tb_thresholding_param_loader;
  localparam int N = 2, K = 8, C = 4, PE = 2, SIGNED = 1;
  localparam int T  = 2 ** N - 1;
  localparam int NW = C * T;
  localparam int CF = 1 + (C - 1) / PE;
  localparam int PEB = $clog2(PE);
  localparam int AB = $clog2(CF) + PEB + N + 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start1 = 1'b0;
  logic busy, done, err, busy1, done1, err1;

  thresholding_param_loader_if #(.ADDR_BITS(AB), .TDATA_BITS(8)) bus ();
  thresholding_param_loader_if #(.ADDR_BITS(3), .TDATA_BITS(8)) bus1 ();

  thresholding_param_loader #(.N(N), .K(K), .C(C), .PE(PE), .SIGNED(SIGNED)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err), .bus(bus));
  thresholding_param_loader #(.N(1), .K(8), .C(1), .PE(1), .SIGNED(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .err(err1), .bus(bus1));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: address from the channel/threshold decomposition.
  function automatic logic [31:0] model_addr(input int j);
    int c, t, cf, pe;
    c = j / T; t = j % T; cf = c / PE; pe = c % PE;
    return 32'((((cf * (1 << PEB)) + pe) * (1 << N) + t) * 4);
  endfunction

  function automatic logic [31:0] model_data(input logic [7:0] w);
    int v;
    v = int'(w);
    if (SIGNED != 0 && v >= (1 << (K - 1))) v = v - (1 << K);
    return 32'(v);
  endfunction

  // Slave / source state
  logic [7:0]  src_q[$];
  logic [31:0] aw_log[$], w_log[$], exp_a[$], exp_d[$];
  int  aw_lat = 0, w_lat = 0, err_idx = -1, aw_cnt = 0, w_cnt = 0;
  bit  lat_rand = 0, tv_rand = 0;
  bit  aw_got = 0, w_got = 0, b_fire = 0, s_fire = 0;
  bit  aw_hold = 0, w_hold = 0, aw_drop = 0, w_drop = 0;
  logic [31:0] aw_hold_val, w_hold_val;
  int  nb = 0, ndone = 0, cyc = 0, first_fetch = -1, done_cyc = 0;

  // Everything is decided on the falling edge, so handshakes it sets up
  // happen at the following rising edge and are logged here in advance.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      bus.m_axilite_AWREADY = 0; bus.m_axilite_WREADY = 0;
      bus.m_axilite_BVALID = 0;  bus.m_axilite_BRESP = 2'b00;
      bus.s_axis_tvalid = 0;     bus.s_axis_tdata = 8'h00;
      aw_got = 0; w_got = 0; b_fire = 0; s_fire = 0; aw_cnt = 0; w_cnt = 0;
      aw_hold = 0; w_hold = 0; aw_drop = 0; w_drop = 0;
    end else begin
      if (done) begin ndone++; done_cyc = cyc; end
      if (bus.s_axis_tready && first_fetch < 0) first_fetch = cyc;
      if (bus.s_axis_tready)
        chk("axil_idle_in_fetch", {bus.m_axilite_AWVALID, bus.m_axilite_WVALID, bus.m_axilite_BREADY}, 0);
      if (b_fire) begin
        bus.m_axilite_BVALID = 0; b_fire = 0; nb++;
        chk("err_after_b", err, (err_idx >= 0 && nb > err_idx));
      end
      if (aw_got && w_got && !bus.m_axilite_BVALID) begin
        bus.m_axilite_BVALID = 1;
        bus.m_axilite_BRESP = (nb == err_idx) ? 2'b10 : 2'b00;
        aw_got = 0; w_got = 0;
      end
      if (bus.m_axilite_BVALID && bus.m_axilite_BREADY) b_fire = 1;

      if (aw_drop) begin chk("awvalid_drop", bus.m_axilite_AWVALID, 0); aw_drop = 0; end
      if (bus.m_axilite_AWVALID) begin
        if (aw_hold) chk("awaddr_stable", 32'(bus.m_axilite_AWADDR), aw_hold_val);
        if (aw_cnt >= aw_lat) bus.m_axilite_AWREADY = 1;
        else begin bus.m_axilite_AWREADY = 0; aw_cnt++; end
        if (bus.m_axilite_AWREADY) begin
          chk("one_outstanding", {aw_got, bus.m_axilite_BVALID}, 0);
          aw_log.push_back(32'(bus.m_axilite_AWADDR));
          aw_got = 1; aw_cnt = 0; aw_hold = 0; aw_drop = 1;
          if (lat_rand) aw_lat = $urandom_range(0, 3);
        end else begin
          aw_hold = 1; aw_hold_val = 32'(bus.m_axilite_AWADDR);
        end
      end else begin
        bus.m_axilite_AWREADY = 0; aw_cnt = 0; aw_hold = 0;
      end

      if (w_drop) begin chk("wvalid_drop", bus.m_axilite_WVALID, 0); w_drop = 0; end
      if (bus.m_axilite_WVALID) begin
        if (w_hold) chk("wdata_stable", bus.m_axilite_WDATA, w_hold_val);
        if (w_cnt >= w_lat) bus.m_axilite_WREADY = 1;
        else begin bus.m_axilite_WREADY = 0; w_cnt++; end
        if (bus.m_axilite_WREADY) begin
          chk("wstrb", bus.m_axilite_WSTRB, 4'hF);
          w_log.push_back(bus.m_axilite_WDATA);
          w_got = 1; w_cnt = 0; w_hold = 0; w_drop = 1;
          if (lat_rand) w_lat = $urandom_range(0, 3);
        end else begin
          w_hold = 1; w_hold_val = bus.m_axilite_WDATA;
        end
      end else begin
        bus.m_axilite_WREADY = 0; w_cnt = 0; w_hold = 0;
      end

      if (s_fire) begin void'(src_q.pop_front()); s_fire = 0; end
      bus.s_axis_tvalid = (src_q.size() > 0) && (!tv_rand || ($urandom_range(0, 1) == 1));
      bus.s_axis_tdata  = bus.s_axis_tvalid ? src_q[0] : 8'h00;
      if (bus.s_axis_tvalid && bus.s_axis_tready) s_fire = 1;
    end
  end

  task automatic prep(input bit rv, input bit lr, input int al, input int wl, input int ei);
    tv_rand = rv; lat_rand = lr; aw_lat = al; w_lat = wl; err_idx = ei;
    aw_log.delete(); w_log.delete(); exp_a.delete(); exp_d.delete();
    nb = 0; ndone = 0; first_fetch = -1;
    for (int j = 0; j < NW; j++) begin
      exp_a.push_back(model_addr(j));
      exp_d.push_back(model_data(src_q[j]));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int to = 0;
    while (!done && to < 3000) begin @(negedge clk); to++; end
    chk(name, done, 1);
  endtask

  task automatic check_load(input string tag);
    chk({tag, "_n_aw"}, aw_log.size(), NW);
    chk({tag, "_n_w"}, w_log.size(), NW);
    chk({tag, "_n_b"}, nb, NW);
    for (int i = 0; i < NW && i < aw_log.size(); i++) chk({tag, "_awaddr"}, aw_log[i], exp_a[i]);
    for (int i = 0; i < NW && i < w_log.size(); i++)  chk({tag, "_wdata"}, w_log[i], exp_d[i]);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
  endtask

  typedef struct { logic [7:0] word; int widx; logic [31:0] wdata; } vec_t;
  vec_t tab[NW];
  logic [7:0]  zw[4];
  logic [31:0] zexp[4];

  initial begin
    tab = '{'{8'd1, 0, 32'd1},   '{8'd2, 1, 32'd2},   '{8'd3, 2, 32'd3},
            '{8'd4, 4, 32'd4},   '{8'd5, 5, 32'd5},   '{8'd6, 6, 32'd6},
            '{8'd7, 8, 32'd7},   '{8'd8, 9, 32'd8},   '{8'd9, 10, 32'd9},
            '{8'd10, 12, 32'd10}, '{8'd11, 13, 32'd11}, '{8'd12, 14, 32'd12}};
    zw   = '{8'h80, 8'hFF, 8'h7F, 8'h01};
    zexp = '{32'h00000080, 32'h000000FF, 32'h0000007F, 32'h00000001};
    bus1.m_axilite_AWREADY = 1; bus1.m_axilite_WREADY = 1;
    bus1.m_axilite_BVALID = 1;  bus1.m_axilite_BRESP = 2'b00;
    bus1.s_axis_tvalid = 0;     bus1.s_axis_tdata = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, err, bus.s_axis_tready, bus.m_axilite_AWVALID,
        bus.m_axilite_WVALID, bus.m_axilite_BREADY}, 0);
    chk("reset_outputs_u1", {busy1, done1, err1, bus1.s_axis_tready, bus1.m_axilite_AWVALID}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, bus.s_axis_tready}, 0);

    // Natural-order load with the ideal slave
    for (int i = 0; i < NW; i++) src_q.push_back(tab[i].word);
    src_q.push_back(8'hAA); src_q.push_back(8'h55);
    prep(0, 0, 0, 0, -1);
    pulse_start();
    chk("busy_after_start", busy, 1);
    wait_done("t1_done");
    @(negedge clk);
    check_load("t1");
    for (int i = 0; i < NW && i < aw_log.size(); i++) begin
      chk("t1_tab_addr", aw_log[i] >> 2, tab[i].widx);
      chk("t1_tab_data", w_log[i], tab[i].wdata);
    end
    chk("t1_done_latency", done_cyc - first_fetch, 36);
    chk("t1_err", err, 0);
    repeat (10) @(negedge clk);
    chk("extra_words_kept", src_q.size(), 2);
    chk("t1_done_once", ndone, 1);
    chk("tready_after_done", bus.s_axis_tready, 0);
    src_q.delete();

    // Sign extension, then a start on the done cycle, then AW held off
    src_q.push_back(8'h80); fill_random(NW - 1); fill_random(NW);
    prep(0, 0, 0, 0, -1);
    pulse_start();
    wait_done("t2_done");
    start = 1'b1;
    @(negedge clk);
    chk("start_on_done_ignored", busy, 0);
    check_load("t2");
    if (w_log.size() > 0) chk("wdata_80_signed", w_log[0], 32'hFFFFFF80);
    else chk("wdata_80_present", w_log.size(), 1);
    prep(0, 0, 3, 0, -1);
    @(negedge clk);
    chk("start_after_done_taken", busy, 1);
    start = 1'b0;
    wait_done("t3a_done");
    @(negedge clk);
    check_load("t3a");

    // W held off instead
    fill_random(NW);
    prep(0, 0, 0, 3, -1);
    pulse_start();
    wait_done("t3b_done");
    @(negedge clk);
    check_load("t3b");

    // Error response on the fifth write
    fill_random(NW);
    prep(0, 1, 1, 2, 4);
    pulse_start();
    wait_done("t4_done");
    @(negedge clk);
    check_load("t4");
    chk("t4_done_once", ndone, 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);

    // Randomized stream stalls and slave latency with a stray start
    for (int it = 0; it < 3; it++) begin
      fill_random(NW);
      prep(1, 1, $urandom_range(0, 3), $urandom_range(0, 3), -1);
      pulse_start();
      chk("err_cleared_by_start", err, 0);
      repeat (10) @(negedge clk);
      chk("busy_mid_load", busy, 1);
      pulse_start();
      wait_done("t5_done");
      @(negedge clk);
      check_load("t5");
      repeat (4) @(negedge clk);
      chk("stray_start_no_reload", {busy, 8'(ndone)}, 1);
    end

    // Reset in the middle of a write
    fill_random(NW);
    prep(0, 0, 50, 50, -1);
    pulse_start();
    begin
      int to = 0;
      while (!bus.m_axilite_AWVALID && to < 50) begin @(negedge clk); to++; end
    end
    chk("t6_awvalid_reached", bus.m_axilite_AWVALID, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_load", {busy, done, bus.s_axis_tready, bus.m_axilite_AWVALID,
        bus.m_axilite_WVALID, bus.m_axilite_BREADY}, 0);
    rst = 1'b0;
    src_q.delete();
    @(negedge clk);
    chk("rst_stays_idle", busy, 0);
    fill_random(NW);
    prep(0, 0, 0, 0, -1);
    pulse_start();
    wait_done("t6_done");
    @(negedge clk);
    check_load("t6");
    if (aw_log.size() > 0) chk("reload_from_zero", aw_log[0], 0);
    else chk("reload_present", aw_log.size(), 1);

    // Zero-extending instance with degenerate C=1, PE=1 fields
    for (int i = 0; i < 4; i++) begin
      int to;
      bus1.s_axis_tdata = zw[i]; bus1.s_axis_tvalid = 1'b1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      to = 0;
      while (!bus1.m_axilite_WVALID && to < 20) begin @(negedge clk); to++; end
      chk("u1_wvalid_seen", bus1.m_axilite_WVALID, 1);
      bus1.s_axis_tvalid = 1'b0;
      chk("u1_wdata", bus1.m_axilite_WDATA, zexp[i]);
      chk("u1_awaddr", bus1.m_axilite_AWADDR, 0);
      to = 0;
      while (!done1 && to < 20) begin @(negedge clk); to++; end
      chk("u1_done", done1, 1);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/thresholding_param_loader.md
Name: thresholding_param_loader

Overview:
Upstream configuration feeder for the AXI-Lite-configured thresholding stage. It consumes a flat AXI-Stream of threshold words in natural channel order. It converts each word into one AXI-Lite write (AW/W/B), with the byte address laid out exactly as the thresholding adapter's parameter map expects. A single start pulse loads a complete threshold set; busy/done/err report progress to the controlling logic.

Parameters:
N, 4, output precision; each channel has 2**N-1 thresholds, indices 0..2**N-2
K, 16, threshold precision in bits
C, 1, channel count
PE, 1, PE parallelism of the target; C%PE==0 required (elaboration $error otherwise)
SIGNED, 1, 1: WDATA sign-extended from bit K-1; 0: zero-extended
CF (localparam), 1+(C-1)/PE, channel fold
ADDR_BITS (localparam), $clog2(CF)+$clog2(PE)+N+2, target address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle load request; honoured only in IDLE
busy  out  1  high from the cycle after an accepted start until the final B handshake
done  out  1  one-cycle pulse on the cycle after the final B handshake
err  out  1  sticky; set when any BRESP!=0; cleared by rst or an accepted start
s_axis_tready  out  1  threshold stream ready
s_axis_tvalid  in  1  threshold stream valid
s_axis_tdata  in  ((K+7)/8)*8  threshold word in bits [K-1:0]; upper bits ignored
m_axilite_AWVALID  out  1
m_axilite_AWREADY  in  1
m_axilite_AWADDR  out  ADDR_BITS  byte address, bits [1:0]=0
m_axilite_WVALID  out  1
m_axilite_WREADY  in  1
m_axilite_WDATA  out  32  extended threshold
m_axilite_WSTRB  out  4  always 4'hF
m_axilite_BVALID  in  1
m_axilite_BREADY  out  1
m_axilite_BRESP  in  2

Behaviour:
- Reset values: state IDLE; all counters 0; busy, done, err, tready, AWVALID, WVALID and BREADY all 0.
- Counters: t (0..2**N-2, innermost), pe (0..PE-1), cf (0..CF-1, outermost). Stream word j maps to channel c=cf*PE+pe, threshold t.
- Address: AWADDR = {cf, pe, t, 2'b00}.
  - t occupies [2+:N]; pe occupies [N+2+:$clog2(PE)]; cf occupies [N+2+$clog2(PE)+:$clog2(CF)].
  - A field of width 0 is omitted.
- FSM states: IDLE, FETCH, ISSUE, RESP.
- IDLE: on start, clear counters and err, then go to FETCH.
- FETCH: tready=1. On tvalid&&tready, register the data and address, then go to ISSUE.
  - No other state asserts tready.
- ISSUE: AWVALID and WVALID both rise on entry.
  - Each drops on its own handshake; per-channel done flags track this.
  - AW and W may complete in either order or in the same cycle.
  - AWADDR, WDATA and WSTRB stay stable while the corresponding VALID is high.
  - When both are done (including the cycle the second handshake occurs), go to RESP.
- RESP: BREADY=1. On BVALID:
  - Set err if BRESP!=0. Loading continues regardless of error.
  - If t, pe and cf are all at their maximum, go to IDLE and pulse done.
  - Otherwise advance the counters (t wraps to 0 and carries into pe; pe wraps to 0 and carries into cf) and go to FETCH.
- Outstanding transactions: at most one AXI-Lite write at a time. Total writes per load = C*(2**N-1).
- Throughput: 3 cycles per word against a slave that accepts AW/W immediately and answers B one cycle later.
- Boundary conditions:
  - start while busy: ignored.
  - start in the same cycle as done: ignored; a new start is accepted from the following cycle.
  - Stream stall in FETCH: wait indefinitely; AXI-Lite outputs remain idle.
  - Extra stream words after done: not consumed (tready=0).
  - rst mid-load: immediate return to IDLE with all outputs deasserted. The partially written threshold set is not rolled back. The target must share the same reset so that no half-open AXI-Lite transaction survives.
  - C=1 and/or PE=1: the degenerate fields vanish; t still sweeps 0..2**N-2.

Test Plan:
1. N=2, K=8, C=4, PE=2, ideal slave; start, then stream words 1..12 → 12 writes with AWADDR (word>>2) = 0,1,2,4,5,6,8,9,10,12,13,14; WDATA = sign-extended 1..12; done pulses once, 36 cycles after the first FETCH with tvalid constantly high; err=0.
2. SIGNED=1, K=8, word 8'h80 → WDATA=32'hFFFFFF80. SIGNED=0 with the same word → 32'h00000080.
3. Slave with AWREADY delayed 3 cycles and WREADY immediate, then the reverse → WVALID/AWVALID each drop exactly after their own handshake; AWADDR/WDATA stable while valid; a single B accepted per word.
4. BRESP=2'b10 on write 5 of 12 → err=1 from that cycle; all 12 writes still issued; done pulses; err stays 1 until the next start.
5. tvalid toggling randomly, plus start asserted while busy → no writes while the stream stalls; the extra start has no effect; write count is exactly C*(2**N-1).
6. rst asserted while in ISSUE with AWVALID=1 → next cycle AWVALID=WVALID=BREADY=busy=0 and state IDLE; a fresh start then reloads from address 0.
